// File: rtl/store_narrow_serializer.sv
// store_narrow_serializer: truncates a 64-bit store value and writes it little-endian, one byte per cycle
module store_narrow_serializer #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              narrow_ovf
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [63:0] data;
    logic [3:0] cnt;
    logic ovf, ovf_nx, accept, last;
    assign accept = req_valid && state == IDLE;
    assign last = state == SEND && cnt == 4'd1 && mem_ready;
    // Overflow when the narrowed value, sign-extended back, differs from the register value
    assign ovf_nx = req_size == 2'd0 ? req_data != {{56{req_data[7]}}, req_data[7:0]} :
                    req_size == 2'd1 ? req_data != {{48{req_data[15]}}, req_data[15:0]} :
                    req_size == 2'd2 ? req_data != {{32{req_data[31]}}, req_data[31:0]} : 1'b0;
    always_comb begin
        state_nx = IDLE;
        state_nx = state == IDLE ? (req_valid ? SEND : IDLE) :
                   state == SEND ? (last ? DONE : SEND) : IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    // data shifts right as bytes are taken, so the current byte is always data[7:0]
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
            data <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else if (accept) begin
            addr <= req_addr;
            data <= req_data;
            cnt  <= 4'd1 << req_size;
            ovf  <= ovf_nx;
        end else if (state == SEND && mem_ready) begin
            addr <= addr + ADDR_W'(1);
            data <= {8'h00, data[63:8]};
            cnt  <= cnt - 4'd1;
        end
    end
    assign req_ready  = state == IDLE;
    assign mem_we     = state == SEND;
    assign mem_addr   = addr;
    assign mem_wdata  = data[7:0];
    assign done       = state == DONE;
    assign narrow_ovf = state == DONE && ovf;
endmodule

// File: doc/store_narrow_serializer.md
Name: store_narrow_serializer

Overview:
- Write-side counterpart of the immediate/load sign extender: takes a 64-bit register value and a store size (STURB/STURH/STURW/STUR), truncates it, and streams it little-endian one byte per cycle onto a byte-wide data-memory write port.
- Flags values that do not survive a truncate-then-sign-extend round trip.
- Sits between the EX/MEM store path and the byte-addressed data memory.

Parameters:
ADDR_W, 64, width of byte address.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
req_valid  in  1  store request valid
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  byte address of least-significant byte
req_data  in  64  register value to store
req_size  in  2  0=byte, 1=half, 2=word, 3=dword
mem_we  out  1  byte write strobe
mem_addr  out  ADDR_W  byte write address
mem_wdata  out  8  byte write data
mem_ready  in  1  memory accepts the current byte this cycle
done  out  1  one-cycle pulse: request fully written
narrow_ovf  out  1  valid with done: truncated value is not equal to req_data after sign extension

Behaviour:
Reset:
- Asynchronous on reset=0; the block returns to IDLE.
- req_ready=1; mem_we=0, mem_addr=0, mem_wdata=0, done=0, narrow_ovf=0.
- Internal address, data, count and ovf registers are cleared.

Handshake and accept:
- Accept when req_valid & req_ready at a rising edge.
- req_ready=1 only in IDLE.
- On accept, the block latches addr, data and N=2^req_size bytes, then enters SEND.

States:
- IDLE: req_ready=1, mem_we=0. Accept -> SEND.
- SEND: mem_we=1, mem_addr=base+k (mod 2^ADDR_W), mem_wdata=data[8k+7:8k], k=0..N-1.
  - mem_ready=1: k increments.
  - mem_ready=0: mem_addr and mem_wdata hold stable, mem_we stays 1.
  - Last byte accepted (k=N-1 & mem_ready) -> DONE.
- DONE: done=1 and narrow_ovf valid for exactly one cycle, mem_we=0, req_ready=0 -> IDLE.

Overflow rule:
- Computed at accept and registered.
- For N<8: narrow_ovf=1 unless bits req_data[63:8N-1] are all equal.
- For N=8: narrow_ovf=0.
- Outside DONE: narrow_ovf=0.

Latency and throughput:
- Accept at edge 0; byte k is presented in cycle k+1 with no stalls.
- done is in cycle N+1.
- Next accept is possible at the edge ending cycle N+2, so a new request occupies N+2 cycles.

Boundaries:
- req_valid in SEND or DONE is ignored; the requester must hold it.
- Address wrap-around is modular: base=2^ADDR_W-1 with N=2 writes to addresses all-ones and then 0.
- mem_ready is ignored outside SEND.
- Reset asserted mid-SEND aborts the store immediately: remaining bytes are not written and no done pulse is generated. Bytes already written stay in memory.

Outputs: all registered; no combinational path from req_* or mem_ready to any output.

Test Plan:
1. Reset values: assert reset=0 mid-SEND of a dword store -> mem_we=0, done=0, narrow_ovf=0 and req_ready=1 immediately. After release, no further writes occur.
2. Byte store: size=0, addr=0x100, data=0xFFFF_FFFF_FFFF_FF85, mem_ready=1 -> cycle 1 we=1 addr=0x100 wdata=0x85. Cycle 2 done=1, narrow_ovf=0.
3. Word store, mem_ready held 1: size=2, addr=0x200, data=0x0000_0000_1234_5678 -> addr/wdata sequence 0x200/78, 0x201/56, 0x202/34, 0x203/12 in cycles 1-4. done in cycle 5, narrow_ovf=0.
4. Half-store overflow: size=1, data=0x0000_0000_0000_8000 -> 2 bytes 00, 80 written and narrow_ovf=1 with done. Repeat with data=0xFFFF_FFFF_FFFF_8000 -> narrow_ovf=0.
5. Stall: dword store, data=0x0102030405060708, mem_ready=0 for 3 cycles while byte 2 is presented -> addr and wdata=0x06 held for those cycles. All 8 bytes are written in order and done appears 3 cycles later than the unstalled case.
6. Busy and wrap: size=1, addr=all-ones, with req_valid held high throughout -> writes to all-ones then 0. req_ready=0 during SEND and DONE; the second request is accepted only on return to IDLE.
